// File: rtl/i2s_stereo_tx.sv
// I2S stereo transmitter: stereo-pair FIFO feeding a 64-slot frame serializer with mclk/bclk/lrclk dividers.
// Define I2S_STEREO_TX_HOLD_LAST_EN to repeat the last popped pair on underrun instead of sending zeros.
module i2s_stereo_tx #(
  parameter int clk_mhz    = 50,
  parameter int w_sample   = 16,
  parameter int fifo_depth = 8,
  parameter int bclk_half  = 8,
  parameter int mclk_half  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [w_sample-1:0]           in_left,
  input  logic [w_sample-1:0]           in_right,
  output logic                          underrun,
  output logic [$clog2(fifo_depth):0]   fifo_level,
  output logic                          mclk,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata
);

  localparam int AW  = $clog2(fifo_depth);
  localparam int MW  = $clog2(mclk_half + 1);
  localparam int BW  = $clog2(bclk_half + 1);
  localparam int PAD = 32 - w_sample;
  localparam longint FRAME_HZ = longint'(clk_mhz) * 64'd1000000 / longint'(128 * bclk_half);
  localparam logic [AW:0]   DEPTH_L = fifo_depth[AW:0];
  localparam logic [MW-1:0] M_TOP   = MW'(mclk_half - 1);
  localparam logic [BW-1:0] B_TOP   = BW'(bclk_half - 1);

  generate
    if (w_sample < 8 || w_sample > 32 || fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0 ||
        bclk_half < 2 || mclk_half < 1 || FRAME_HZ < 1) begin : g_bad_param
      $error("i2s_stereo_tx: illegal parameter set");
    end
  endgenerate

  logic [w_sample-1:0] mem_l [fifo_depth];
  logic [w_sample-1:0] mem_r [fifo_depth];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [MW-1:0]       mclk_cnt;
  logic [BW-1:0]       bclk_cnt;
  logic [5:0]          slot, next_slot;
  logic [63:0]         pend, sh;
  logic [31:0]         word_l, word_r;
  logic                push, pop, fall, load;

  assign in_ready  = (fifo_level != DEPTH_L);
  assign push      = in_valid && in_ready;
  assign fall      = bclk && (bclk_cnt == B_TOP);
  assign next_slot = slot + 6'd1;
  assign load      = fall && (next_slot == 6'd63);
  assign pop       = load && (fifo_level != '0);
  assign word_l    = 32'(mem_l[rd_ptr]) << PAD;
  assign word_r    = 32'(mem_r[rd_ptr]) << PAD;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= in_left;
      mem_r[wr_ptr] <= in_right;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mclk_cnt <= '0;
      mclk     <= 1'b0;
      bclk_cnt <= '0;
      bclk     <= 1'b0;
    end else begin
      if (mclk_cnt == M_TOP) begin
        mclk     <= ~mclk;
        mclk_cnt <= '0;
      end else begin
        mclk_cnt <= mclk_cnt + 1'b1;
      end
      if (bclk_cnt == B_TOP) begin
        bclk     <= ~bclk;
        bclk_cnt <= '0;
      end else begin
        bclk_cnt <= bclk_cnt + 1'b1;
      end
    end
  end

  // pend holds the next frame; it is loaded at slot 63 while slot 63 still shifts out the old right LSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (load) begin
      if (fifo_level != '0) pend <= {word_l, word_r};
`ifdef I2S_STEREO_TX_HOLD_LAST_EN
      else pend <= pend;
`else
      else pend <= '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot     <= 6'd63;
      sh       <= '0;
      sdata    <= 1'b0;
      lrclk    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= load && (fifo_level == '0);
      if (fall) begin
        slot  <= next_slot;
        lrclk <= (next_slot >= 6'd31) && (next_slot <= 6'd62);
        if (next_slot == 6'd0) begin
          sdata <= pend[63];
          sh    <= {pend[62:0], 1'b0};
        end else begin
          sdata <= sh[63];
          sh    <= {sh[62:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Bench for i2s_stereo_tx: directed steps, sdata decoded at rising bclk and checked against a pair scoreboard.
module tb_i2s_stereo_tx;

`ifdef I2S_STEREO_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        in_ready, underrun, mclk, bclk, lrclk, sdata;
  logic [3:0]  fifo_level;

  i2s_stereo_tx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .underrun(underrun),
    .fifo_level(fifo_level), .mclk(mclk), .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] frame_of(input logic [15:0] l, input logic [15:0] r);
    return {l, 16'h0000, r, 16'h0000};
  endfunction

  // Scoreboard and sdata decoder
  logic [63:0] sb_q[$];
  logic [63:0] mon_sh = '0, mon_exp = '0, mon_last_pop = '0, mon_last_frame = '0;
  bit mon_pb = 0, mon_plr = 0, mon_ur = 0;
  int frames = 0, ur_total = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_pb = 0; mon_plr = 0; mon_ur = 0;
      mon_sh = '0; mon_exp = '0; mon_last_pop = '0;
    end else begin
      if (underrun) begin
        mon_ur = 1;
        ur_total++;
      end
      if (bclk && !mon_pb) begin
        mon_sh = {mon_sh[62:0], sdata};
        if (!lrclk && mon_plr) begin
          chk("frame", mon_sh, mon_exp);
          mon_last_frame = mon_sh;
          frames++;
          if (mon_ur) begin
            mon_exp = HOLD ? mon_last_pop : 64'h0;
          end else begin
            chk("pop_model_nonempty", 64'(sb_q.size() != 0), 64'h1);
            if (sb_q.size() != 0) begin
              mon_exp = sb_q.pop_front();
              mon_last_pop = mon_exp;
            end
          end
          mon_ur = 0;
        end
        mon_plr = lrclk;
      end
      mon_pb = bclk;
    end
  end

  // Period and pulse-width measurement
  int m_last = -1, b_last = -1, l_last = -1, u_last = -1;
  int m_per = 0, b_per = 0, l_per = 0, u_per = 0, ur_hi = 0, ur_width = 0;
  bit p_m = 0, p_b = 0, p_l = 0, p_u = 0;
  always @(negedge clk) begin
    if (rst) begin
      m_last = -1; b_last = -1; l_last = -1; u_last = -1; ur_hi = 0;
    end else begin
      if (mclk && !p_m) begin if (m_last >= 0) m_per = cyc - m_last; m_last = cyc; end
      if (bclk && !p_b) begin if (b_last >= 0) b_per = cyc - b_last; b_last = cyc; end
      if (lrclk && !p_l) begin if (l_last >= 0) l_per = cyc - l_last; l_last = cyc; end
      if (underrun && !p_u) begin if (u_last >= 0) u_per = cyc - u_last; u_last = cyc; end
      if (underrun) ur_hi++;
      else if (p_u) begin ur_width = ur_hi; ur_hi = 0; end
    end
    p_m = mclk; p_b = bclk; p_l = lrclk; p_u = underrun;
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r, input int limit, output int waited);
    in_left = l; in_right = r; in_valid = 1'b1; waited = 0;
    while (!in_ready && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    chk("send_accept", 64'(in_ready), 64'h1);
    if (in_ready) sb_q.push_back(frame_of(l, r));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // which: 0 = lrclk rise, 1 = underrun rise
  task automatic wait_rise(input int which, input int limit);
    bit prev, cur, ok;
    prev = (which == 0) ? lrclk : underrun;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      cur = (which == 0) ? lrclk : underrun;
      if (cur && !prev) ok = 1;
      prev = cur;
    end
    chk("wait_rise_timeout", 64'(ok), 64'h1);
  endtask

  task automatic wait_frames(input int n);
    int f0;
    f0 = frames;
    for (int i = 0; i < n * 1100 + 100 && frames < f0 + n; i++) @(negedge clk);
    chk("wait_frames_timeout", 64'(frames >= f0 + n), 64'h1);
  endtask

  task automatic check_next_frame(input string tag, input logic [63:0] exp);
    for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
    chk("queue_drain_timeout", 64'(sb_q.size()), 64'h0);
    wait_frames(1);
    chk(tag, mon_last_frame, exp);
  endtask

  initial begin
    int w, c0, u0, n;
    repeat (3) @(negedge clk);
    chk("rst_mclk", 64'(mclk), 64'h0);
    chk("rst_bclk", 64'(bclk), 64'h0);
    chk("rst_lrclk", 64'(lrclk), 64'h0);
    chk("rst_sdata", 64'(sdata), 64'h0);
    chk("rst_underrun", 64'(underrun), 64'h0);
    chk("rst_level", 64'(fifo_level), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    rst = 1'b0;

    // Idle: clock periods and periodic underrun
    repeat (3500) @(negedge clk);
    chk("mclk_period", 64'(m_per), 64'd4);
    chk("bclk_period", 64'(b_per), 64'd16);
    chk("lrclk_period", 64'(l_per), 64'd1024);
    chk("underrun_period", 64'(u_per), 64'd1024);
    chk("underrun_width", 64'(ur_width), 64'd1);

    // Bit order
    send(16'h8001, 16'h7FFE, 10, w);
    check_next_frame("bitorder_word", 64'h80010000_7FFE0000);

    // Full: 8 accepted back-to-back right after a load, 9th waits for the next pop
    wait_rise(1, 3000);
    for (int i = 0; i < 8; i++) send(16'h1000 + 16'(i), 16'hF000 - 16'(i), 10, w);
    chk("full_in_ready", 64'(in_ready), 64'h0);
    chk("full_level", 64'(fifo_level), 64'd8);
    send(16'h2222, 16'hDDDD, 2000, w);
    chk("full_ninth_waited", 64'(w > 500), 64'h1);
    chk("full_level_after_ninth", 64'(fifo_level), 64'd8);
    for (int i = 0; i < 12000 && fifo_level != 0; i++) @(negedge clk);
    chk("full_drained", 64'(fifo_level), 64'h0);
    wait_frames(2);

    // Write lands in the pop cycle with three pairs stored
    wait_rise(0, 3000);
    c0 = cyc;
    send(16'h0A01, 16'hB501, 10, w);
    send(16'h0A02, 16'hB502, 10, w);
    send(16'h0A03, 16'hB503, 10, w);
    for (int i = 0; i < 600 && cyc != c0 + 511; i++) @(negedge clk);
    chk("simul_level_before", 64'(fifo_level), 64'd3);
    send(16'h0A04, 16'hB504, 10, w);
    chk("simul_level_after", 64'(fifo_level), 64'd3);
    wait_frames(5);

    // Underrun data after one pair
    send(16'h1234, 16'hABCD, 10, w);
    check_next_frame("underrun_pair_word", 64'h12340000_ABCD0000);
    u0 = ur_total;
    wait_frames(3);
    chk("underrun_pulses", 64'(ur_total - u0), 64'd3);
    chk("underrun_word", mon_last_frame, HOLD ? 64'h12340000_ABCD0000 : 64'h0);

    // Reset at slot 40 with pairs stored
    send(16'h5555, 16'h6666, 10, w);
    send(16'h7777, 16'h8888, 10, w);
    wait_rise(0, 3000);
    repeat (144) @(negedge clk);
    #2 rst = 1'b1;
    sb_q.delete();
    #1;
    chk("midrst_mclk", 64'(mclk), 64'h0);
    chk("midrst_bclk", 64'(bclk), 64'h0);
    chk("midrst_lrclk", 64'(lrclk), 64'h0);
    chk("midrst_sdata", 64'(sdata), 64'h0);
    chk("midrst_underrun", 64'(underrun), 64'h0);
    chk("midrst_level", 64'(fifo_level), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'h1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 2000 && n == 0; i++) begin
      @(negedge clk);
      if (lrclk) n = i;
    end
    chk("restart_first_lrclk", 64'(n), 64'd512);
    chk("restart_level", 64'(fifo_level), 64'h0);
    send(16'h0F0F, 16'hF0F0, 10, w);
    check_next_frame("restart_word", 64'h0F0F0000_F0F00000);

    wait_frames(1);
    chk("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
